mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk rising edge, rst_n sampled only on clk.
REQ-002 Parameter WORDS, default 8, SHALL set the number of rows (bitcell words).
REQ-003 Parameter WIDTH, default 8, SHALL set the bits per row.
REQ-004 Parameter ACCESS_CYCLES, default 1, legal 1..15, SHALL set the cycles row select is held for a write strobe.
REQ-005 Port: clk  in  1  system clock.
REQ-006 Port: rst_n  in  1  synchronous active-low reset.
REQ-007 Port: req_valid  in  1  request present.
REQ-008 Port: req_ready  out  1  block accepts a request this cycle.
REQ-009 Port: req_rw  in  1  1 = write, 0 = read (same polarity as bitcell rw).
REQ-010 Port: req_addr  in  $clog2(WORDS)  row address.
REQ-011 Port: req_wdata  in  WIDTH  write data.
REQ-012 Port: rsp_valid  out  1  one-cycle completion pulse, reads and writes.
REQ-013 Port: rsp_rdata  out  WIDTH  read data, valid with rsp_valid on reads.
REQ-014 Port: row_sel  out  WORDS  one-hot select, bit i drives sel of every bitcell in row i.
REQ-015 Port: cell_rw  out  1  drives rw of all bitcells.
REQ-016 Port: cell_data  out  WIDTH  bit j drives data of column j.
REQ-017 Port: cell_out  in  WIDTH  column-wise OR of cellOut from all rows.

Function
REQ-018 Handshake: accept when req_valid && req_ready; req_ready SHALL be 1 only in IDLE; requests offered while busy SHALL be ignored, not queued.
REQ-019 On accept, req_rw, req_addr and req_wdata SHALL be latched; later input changes SHALL not affect the operation.
REQ-020 FSM states SHALL be IDLE, SETUP, STROBE, CAPTURE, RESP.
REQ-021 Transitions: IDLE->SETUP on accept; SETUP->STROBE; STROBE->STROBE until ACCESS_CYCLES cycles elapse, then ->RESP (write) or ->CAPTURE (read); CAPTURE->RESP; RESP->IDLE.
REQ-022 Read STROBE SHALL last exactly 1 cycle regardless of ACCESS_CYCLES.
REQ-023 All cell-side outputs SHALL be registered.
REQ-024 SETUP: row_sel = 0; cell_rw and cell_data SHALL already carry the latched values, giving one cycle of setup before select.
REQ-025 STROBE: row_sel = one-hot of latched addr; cell_rw = latched rw.
REQ-026 CAPTURE (reads only): row_sel held, cell_rw = 0; rsp_rdata SHALL load cell_out at the end of this cycle.
REQ-027 RESP: row_sel = 0, rsp_valid = 1 for exactly one cycle; on writes rsp_rdata SHALL hold its previous value.
REQ-028 IDLE: row_sel = 0, cell_rw = 0, rsp_valid = 0; cell_data holds last value.
REQ-029 Latency (accept at cycle T, ACCESS_CYCLES = N): write rsp_valid at T+2+N; read rsp_valid at T+4.
REQ-030 Back-to-back: a new request SHALL be accepted the cycle after RESP (IDLE); minimum request spacing = latency + 1.
REQ-031 row_sel SHALL never have more than one bit set in any cycle.
REQ-032 An internal strobe counter SHALL be 4 bits wide, count 1..ACCESS_CYCLES, and never wrap.

Reset
REQ-033 With rst_n = 0 at a clk edge: state = IDLE, row_sel = 0, cell_rw = 0, cell_data = 0, rsp_valid = 0, rsp_rdata = 0, req_ready = 1 the following cycle.
REQ-034 Reset mid-operation SHALL abort at once, with no rsp_valid for the aborted request; a partially strobed write leaves that row undefined.

Structure
REQ-035 Package mem_pkg SHALL hold the FSM state enum and the WORDS/WIDTH defaults, shared with the array top level.
REQ-036 One sub-module, row_decoder, SHALL implement the address-to-one-hot decode with an enable input.

Verification
REQ-037 Reset, then idle 5 cycles -> row_sel = 0, rsp_valid = 0, req_ready = 1 throughout.
REQ-038 Write addr 3, data 0xA5, N = 1, accept at T -> row_sel = 0x08 and cell_rw = 1 at T+2, rsp_valid at T+3.
REQ-039 Read addr 3 after REQ-038, array model attached -> row_sel = 0x08 at T+2..T+3, rsp_valid at T+4 with rsp_rdata = 0xA5.
REQ-040 req_valid held high with changing addr while busy -> only the first request executes; req_ready = 0 until RESP+1.
REQ-041 Write addr 7, N = 3 -> row_sel = 0x80 for exactly 3 cycles, rsp_valid at T+5.
REQ-042 rst_n = 0 during STROBE of a read -> row_sel = 0 next cycle, no rsp_valid, a new request is accepted normally afterwards.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared FSM state type and array geometry defaults for the bitcell controller
package mem_pkg;

    localparam int WORDS_DEF = 8;
    localparam int WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        CAPTURE,
        RESP
    } state_e;

endpackage

// File: rtl/mem_ctrl_row_decoder.sv
// rtl/mem_ctrl_row_decoder.sv - row address to one-hot select decode with enable
module row_decoder #(
    parameter int WORDS = 8,
    parameter int AW    = 3
) (
    input  logic [AW-1:0]    addr_i,
    input  logic             en_i,
    output logic [WORDS-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < WORDS; i++) begin
            onehot_o[i] = en_i && (addr_i == AW'(i));
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - single-request controller sequencing setup/strobe/capture on a bitcell array
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int WORDS         = WORDS_DEF,
    parameter int WIDTH         = WIDTH_DEF,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_rw,
    input  logic [$clog2(WORDS)-1:0] req_addr,
    input  logic [WIDTH-1:0]         req_wdata,
    output logic                     rsp_valid,
    output logic [WIDTH-1:0]         rsp_rdata,
    output logic [WORDS-1:0]         row_sel,
    output logic                     cell_rw,
    output logic [WIDTH-1:0]         cell_data,
    input  logic [WIDTH-1:0]         cell_out
);

    localparam int       AW          = $clog2(WORDS);
    localparam logic [3:0] STROBE_LAST = 4'(ACCESS_CYCLES);

    state_e             state_q;
    logic               rw_q;
    logic [AW-1:0]      addr_q;
    logic [3:0]         cnt_q;
    logic [WORDS-1:0]   row_sel_q;
    logic [WORDS-1:0]   row_sel_d;
    logic               cell_rw_q;
    logic [WIDTH-1:0]   cell_data_q;
    logic [WIDTH-1:0]   rsp_rdata_q;
    logic               rsp_valid_q;
    logic               accept;
    logic               strobe_done;
    logic               sel_en_d;

    assign accept      = req_valid && (state_q == IDLE);
    // reads always strobe for a single cycle; writes hold select for ACCESS_CYCLES
    assign strobe_done = !rw_q || (cnt_q >= STROBE_LAST);
    assign sel_en_d    = (state_q == SETUP) ||
                         ((state_q == STROBE) && !(rw_q && strobe_done));

    row_decoder #(
        .WORDS (WORDS),
        .AW    (AW)
    ) u_row_decoder (
        .addr_i   (addr_q),
        .en_i     (sel_en_d),
        .onehot_o (row_sel_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= 4'd0;
            row_sel_q   <= '0;
            cell_rw_q   <= 1'b0;
            cell_data_q <= '0;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            row_sel_q   <= row_sel_d;
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        rw_q        <= req_rw;
                        addr_q      <= req_addr;
                        cell_rw_q   <= req_rw;
                        cell_data_q <= req_wdata;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    cnt_q   <= 4'd1;
                    state_q <= STROBE;
                end
                STROBE: begin
                    if (!strobe_done) begin
                        cnt_q <= cnt_q + 4'd1;
                    end else begin
                        cell_rw_q <= 1'b0;
                        if (rw_q) begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            state_q <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    rsp_rdata_q <= cell_out;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign row_sel   = row_sel_q;
    assign cell_rw   = cell_rw_q;
    assign cell_data = cell_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed bench driving two controllers (1 and 3 access cycles) over array models
module tb_mem_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_rw;
    logic [2:0] req_addr;
    logic [7:0] req_wdata;

    logic       ready1, rsp_valid1, cell_rw1;
    logic [7:0] rsp_rdata1, row_sel1, cell_data1, cell_out1;
    logic       ready3, rsp_valid3, cell_rw3;
    logic [7:0] rsp_rdata3, row_sel3, cell_data3, cell_out3;

    logic [7:0] mem1 [8];
    logic [7:0] mem3 [8];

    int vectors;
    int miscompares;
    logic [7:0] last_rd;

    mem_ctrl #(.WORDS(8), .WIDTH(8), .ACCESS_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready1),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .row_sel(row_sel1),
        .cell_rw(cell_rw1), .cell_data(cell_data1), .cell_out(cell_out1)
    );

    mem_ctrl #(.WORDS(8), .WIDTH(8), .ACCESS_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready3),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .row_sel(row_sel3),
        .cell_rw(cell_rw3), .cell_data(cell_data3), .cell_out(cell_out3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (row_sel1[i] && cell_rw1) mem1[i] <= cell_data1;
            if (row_sel3[i] && cell_rw3) mem3[i] <= cell_data3;
        end
    end

    always_comb begin
        cell_out1 = '0;
        cell_out3 = '0;
        for (int i = 0; i < 8; i++) begin
            if (row_sel1[i]) cell_out1 = cell_out1 | mem1[i];
            if (row_sel3[i]) cell_out3 = cell_out3 | mem3[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Request presented at the current negedge is accepted at the next posedge (cycle T);
    // the negedge of cycle T+k is where the k-th round of checks happens.
    task automatic run_op(input logic rw, input logic [2:0] addr, input logic [7:0] data,
                          input bit hold);
        int lat1, lat3, sel1_hi, sel3_hi;
        logic [7:0] onehot;
        logic [7:0] exp_rd;
        lat1    = rw ? 3 : 4;
        lat3    = rw ? 5 : 4;
        sel1_hi = rw ? 2 : 3;
        sel3_hi = rw ? 4 : 3;
        onehot  = 8'd1 << addr;
        exp_rd  = rw ? last_rd : data;
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_wdata = data;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("u1_row_sel", 32'(row_sel1), (k >= 2 && k <= sel1_hi) ? 32'(onehot) : 32'd0);
            chk("u3_row_sel", 32'(row_sel3), (k >= 2 && k <= sel3_hi) ? 32'(onehot) : 32'd0);
            chk("u1_rsp_valid", 32'(rsp_valid1), 32'(k == lat1));
            chk("u3_rsp_valid", 32'(rsp_valid3), 32'(k == lat3));
            chk("u1_req_ready", 32'(ready1), 32'(k > lat1));
            chk("u3_req_ready", 32'(ready3), 32'(k > lat3));
            if (k == 2) begin
                chk("u1_cell_rw", 32'(cell_rw1), 32'(rw));
                chk("u3_cell_rw", 32'(cell_rw3), 32'(rw));
            end
            if (k == lat1) chk("u1_rsp_rdata", 32'(rsp_rdata1), 32'(exp_rd));
            if (k == lat3) chk("u3_rsp_rdata", 32'(rsp_rdata3), 32'(exp_rd));
            if (hold && k < lat1) begin
                req_addr  = 3'($urandom);
                req_wdata = 8'($urandom);
                req_rw    = 1'($urandom);
            end else begin
                req_valid = 1'b0;
            end
        end
        last_rd = exp_rd;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        last_rd     = 8'h00;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_rw      = 1'b0;
        req_addr    = 3'd0;
        req_wdata   = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_cell_data", 32'(cell_data1), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata1), 32'd0);
        chk("rst_cell_rw", 32'(cell_rw1), 32'd0);
        chk("rst_req_ready", 32'(ready1), 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_row_sel", 32'(row_sel1), 32'd0);
            chk("idle_rsp_valid", 32'(rsp_valid1), 32'd0);
            chk("idle_req_ready", 32'(ready1), 32'd1);
        end

        run_op(1'b1, 3'd3, 8'hA5, 1'b0);
        run_op(1'b0, 3'd3, 8'hA5, 1'b0);
        run_op(1'b1, 3'd7, 8'h3C, 1'b1);
        run_op(1'b0, 3'd7, 8'h3C, 1'b0);
        run_op(1'b1, 3'd0, 8'h5A, 1'b0);
        run_op(1'b0, 3'd0, 8'h5A, 1'b0);
        run_op(1'b0, 3'd3, 8'hA5, 1'b0);

        req_valid = 1'b1;
        req_rw    = 1'b0;
        req_addr  = 3'd7;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort_strobe_sel", 32'(row_sel1), 32'h80);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_u1_row_sel", 32'(row_sel1), 32'd0);
        chk("abort_u3_row_sel", 32'(row_sel3), 32'd0);
        chk("abort_u1_ready", 32'(ready1), 32'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_u1_rsp_valid", 32'(rsp_valid1), 32'd0);
            chk("abort_u3_rsp_valid", 32'(rsp_valid3), 32'd0);
        end
        last_rd = 8'h00;
        run_op(1'b1, 3'd5, 8'hC3, 1'b0);
        run_op(1'b0, 3'd7, 8'h3C, 1'b0);
        run_op(1'b0, 3'd5, 8'hC3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

endmodule
